// File: rtl/subtractor_pkg.sv
// subtractor_pkg: FSM state type and digit-counter width helper for serial_subtractor.
package subtractor_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic int cnt_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction
endpackage

// File: rtl/fs_chain.sv
// fs_chain: combinational DIGIT-bit ripple-borrow subtractor built from full-subtractor cells.
module fs_chain #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);
  logic [DIGIT:0] c;
  assign c[0] = bi;
  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign d[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (~x[i] & y[i]) | (~x[i] & c[i]) | (y[i] & c[i]);
  end
  assign bo = c[DIGIT];
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial a - b - b_in with registered borrow and valid/ready handshakes.
module serial_subtractor
  import subtractor_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             zero
);
  localparam int CYCLES = WIDTH / DIGIT;
  localparam int CW = cnt_w(CYCLES);
  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
  end
  state_t state, state_nx;
  logic [WIDTH-1:0] a_r, b_r, diff_nx;
  logic [CW-1:0] cnt;
  logic [DIGIT-1:0] d;
  logic borrow, bo, accept, last;
  fs_chain #(.DIGIT(DIGIT)) u_chain (
    .x (a_r[cnt*DIGIT +: DIGIT]),
    .y (b_r[cnt*DIGIT +: DIGIT]),
    .bi(borrow),
    .d (d),
    .bo(bo)
  );
  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign last      = (cnt == CW'(CYCLES - 1));
  always_comb begin
    diff_nx = diff;
    diff_nx[cnt*DIGIT +: DIGIT] = d;
    state_nx = accept ? BUSY :
               (state == BUSY && last) ? DONE :
               (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      b_out  <= 1'b0;
      zero   <= 1'b0;
    end else if (accept) begin
      a_r    <= a;
      b_r    <= b;
      borrow <= b_in;
      cnt    <= '0;
    end else if (state == BUSY) begin
      diff   <= diff_nx;
      borrow <= bo;
      cnt    <= last ? '0 : cnt + 1'b1;
      if (last) begin
        b_out <= bo;
        zero  <= (diff_nx == '0);
      end
    end
  end
endmodule
